// File: rtl/wb_stage_pkg.sv
// Shared widths, CP0 register numbers and bit positions for the write-back stage.
package wb_stage_pkg;

  localparam int unsigned MsToWsBusWd  = 84;
  localparam int unsigned WsToRfBusWd  = 41;
  localparam int unsigned StallBusWd   = 10;
  localparam int unsigned ForwardBusWd = 33;

  localparam logic [4:0] CrCount   = 5'd9;
  localparam logic [4:0] CrCompare = 5'd11;
  localparam logic [4:0] CrStatus  = 5'd12;
  localparam logic [4:0] CrCause   = 5'd13;
  localparam logic [4:0] CrEpc     = 5'd14;

  localparam logic [31:0] StatusRst   = 32'h0040_0000;
  localparam logic [31:0] StatusWmask = 32'h0000_ff03;
  localparam int unsigned StatusExl   = 1;
  localparam int unsigned CauseTi     = 30;
  localparam int unsigned CauseIp7    = 15;

  typedef struct packed {
    logic        eret;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;

endpackage

// File: rtl/wb_stage_cp0_regs.sv
// CP0 register file: Count/Compare/Status/Cause/EPC, the Count tick and timer interrupt.
module wb_stage_cp0_regs
  import wb_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wen_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        eret_i,
  output logic [31:0] rdata_o,
  output logic [31:0] epc_o
);

  logic        tick_q;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  ip_q, ip_d;
  logic        ti_q, ti_d;

  logic       sel0;
  logic [4:0] rd;
  logic       wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  assign sel0       = (addr_i[2:0] == 3'd0);
  assign rd         = addr_i[7:3];
  assign wr_count   = wen_i && sel0 && (rd == CrCount);
  assign wr_compare = wen_i && sel0 && (rd == CrCompare);
  assign wr_status  = wen_i && sel0 && (rd == CrStatus);
  assign wr_cause   = wen_i && sel0 && (rd == CrCause);
  assign wr_epc     = wen_i && sel0 && (rd == CrEpc);

  always_comb begin
    count_d   = wr_count ? wdata_i : count_q + {31'b0, tick_q};
    compare_d = wr_compare ? wdata_i : compare_q;
    status_d  = status_q;
    if (wr_status) status_d = (status_q & ~StatusWmask) | (wdata_i & StatusWmask);
    if (eret_i) status_d[StatusExl] = 1'b0;
    ip_d  = wr_cause ? wdata_i[9:8] : ip_q;
    epc_d = wr_epc ? wdata_i : epc_q;
    // Writing Compare acknowledges the timer even if the new value matches Count.
    ti_d = ti_q;
    if (wr_compare) ti_d = 1'b0;
    else if (count_d == compare_d) ti_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      status_q  <= StatusRst;
      epc_q     <= '0;
      ip_q      <= '0;
      ti_q      <= 1'b0;
    end else begin
      tick_q    <= ~tick_q;
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      epc_q     <= epc_d;
      ip_q      <= ip_d;
      ti_q      <= ti_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (sel0) begin
      case (rd)
        CrCount:   rdata_o = count_q;
        CrCompare: rdata_o = compare_q;
        CrStatus:  rdata_o = status_q;
        CrEpc:     rdata_o = epc_q;
        CrCause: begin
          rdata_o[CauseTi]  = ti_q;
          rdata_o[CauseIp7] = ti_q;
          rdata_o[9:8]      = ip_q;
        end
        default: rdata_o = '0;
      endcase
    end
  end

  assign epc_o = epc_q;

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: pipeline register, result mux, RF/stall/forward/debug buses and CP0.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ms_to_ws_valid,
  input  logic [MsToWsBusWd-1:0]  ms_to_ws_bus,
  output logic                    ws_allowin,
  output logic [WsToRfBusWd-1:0]  ws_to_rf_bus,
  output logic [StallBusWd-1:0]   stall_ws_bus,
  output logic [ForwardBusWd-1:0] forward_ws_bus,
  output logic                    ws_eret_flush,
  output logic [31:0]             cp0_epc,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  logic      ws_valid_q, ws_valid_d;
  ms_to_ws_t ws_bus_q, ws_bus_d;
  logic      ws_ready_go;

  logic [31:0] cp0_rdata;
  logic [31:0] ws_final_result;
  logic [3:0]  rf_we;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = !ws_valid_q || ws_ready_go;

  always_comb begin
    ws_valid_d = ws_allowin ? ms_to_ws_valid : ws_valid_q;
    ws_bus_d   = (ms_to_ws_valid && ws_allowin) ? ms_to_ws_t'(ms_to_ws_bus) : ws_bus_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ws_valid_q <= 1'b0;
      ws_bus_q   <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      ws_bus_q   <= ws_bus_d;
    end
  end

  wb_stage_cp0_regs u_cp0_regs (
    .clk_i   (clk),
    .rst_ni  (reset),
    .wen_i   (ws_valid_q && ws_bus_q.cp0_wen),
    .addr_i  (ws_bus_q.cp0_addr),
    .wdata_i (ws_bus_q.result),
    .eret_i  (ws_valid_q && ws_bus_q.eret),
    .rdata_o (cp0_rdata),
    .epc_o   (cp0_epc)
  );

  assign ws_final_result = ws_bus_q.res_from_cp0 ? cp0_rdata : ws_bus_q.result;
  assign rf_we           = ws_bus_q.gr_we & {4{ws_valid_q}};

  assign ws_to_rf_bus   = {rf_we, ws_bus_q.dest, ws_final_result};
  assign stall_ws_bus   = {ws_valid_q && (|ws_bus_q.gr_we), rf_we, ws_bus_q.dest};
  assign forward_ws_bus = {ws_valid_q, ws_final_result};
  assign ws_eret_flush  = ws_valid_q && ws_bus_q.eret;

  assign debug_wb_pc       = ws_bus_q.pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = ws_bus_q.dest;
  assign debug_wb_rf_wdata = ws_final_result;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, CP0 corner sequences, random traffic.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ms_to_ws_valid = 1'b0;
  logic [83:0] ms_to_ws_bus = '0;
  logic        ws_allowin;
  logic [40:0] ws_to_rf_bus;
  logic [9:0]  stall_ws_bus;
  logic [32:0] forward_ws_bus;
  logic        ws_eret_flush;
  logic [31:0] cp0_epc, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;

  int checks = 0;
  int failures = 0;

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_allowin        (ws_allowin),
    .ws_to_rf_bus      (ws_to_rf_bus),
    .stall_ws_bus      (stall_ws_bus),
    .forward_ws_bus    (forward_ws_bus),
    .ws_eret_flush     (ws_eret_flush),
    .cp0_epc           (cp0_epc),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  // Reference model: CP0 as an array indexed by register number, plus the stage contents.
  logic [31:0] m_reg [0:31];
  logic        m_ti, m_tick, m_valid;
  logic [83:0] m_bus;

  function automatic logic [83:0] mk(input logic eret, input logic wen, input logic rcp0,
                                     input logic [7:0] addr, input logic [3:0] we,
                                     input logic [4:0] dest, input logic [31:0] res,
                                     input logic [31:0] pc);
    return {eret, wen, rcp0, addr, we, dest, res, pc};
  endfunction

  function automatic logic [31:0] wmask(input int rd);
    case (rd)
      9, 11, 14: return 32'hFFFF_FFFF;
      12:        return 32'h0000_FF03;
      13:        return 32'h0000_0300;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [7:0] a);
    logic [2:0] sel;
    int rd;
    sel = a[2:0];
    rd  = int'(a[7:3]);
    if (sel != 3'd0) return 32'h0;
    case (rd)
      9, 11, 12, 14: return m_reg[rd];
      13:            return m_reg[13] | {1'b0, m_ti, 14'b0, m_ti, 15'b0};
      default:       return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] wd;
    logic        wen;
    int          rd;
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
      m_reg[12] = 32'h0040_0000;
      m_ti = 1'b0; m_tick = 1'b0; m_valid = 1'b0; m_bus = '0;
    end else begin
      wen = m_valid && m_bus[82] && (m_bus[75:73] == 3'd0);
      rd  = int'(m_bus[80:76]);
      wd  = m_bus[63:32];
      m_reg[9] = m_reg[9] + {31'b0, m_tick};
      if (wen) m_reg[rd] = (m_reg[rd] & ~wmask(rd)) | (wd & wmask(rd));
      if (m_valid && m_bus[83]) m_reg[12][1] = 1'b0;
      if (wen && rd == 11) m_ti = 1'b0;
      else if (m_reg[9] == m_reg[11]) m_ti = 1'b1;
      m_tick  = ~m_tick;
      m_valid = ms_to_ws_valid;
      if (ms_to_ws_valid) m_bus = ms_to_ws_bus;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0]  we;
    logic [31:0] fr;
    we = m_bus[72:69] & {4{m_valid}};
    fr = m_bus[81] ? mread(m_bus[80:73]) : m_bus[63:32];
    chk("allowin", 64'(ws_allowin), 64'(1'b1));
    chk("rf_bus", 64'(ws_to_rf_bus), 64'({we, m_bus[68:64], fr}));
    chk("stall_bus", 64'(stall_ws_bus), 64'({m_valid && (|m_bus[72:69]), we, m_bus[68:64]}));
    chk("forward_bus", 64'(forward_ws_bus), 64'({m_valid, fr}));
    chk("eret_flush", 64'(ws_eret_flush), 64'(m_valid && m_bus[83]));
    chk("cp0_epc", 64'(cp0_epc), 64'(m_reg[14]));
    chk("dbg_pc", 64'(debug_wb_pc), 64'(m_bus[31:0]));
    chk("dbg_rf", 64'({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}),
        64'({we, m_bus[68:64], fr}));
  endtask

  task automatic step(input logic v, input logic [83:0] b);
    ms_to_ws_valid = v;
    ms_to_ws_bus   = b;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  typedef struct {
    logic        v;
    logic [83:0] bus;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic        exp_flush;
    logic [31:0] exp_epc;
    logic [9:0]  exp_stall;
  } vec_t;

  localparam logic [7:0] ACount = 8'h48, ACompare = 8'h58, AStatus = 8'h60;
  localparam logic [7:0] ACause = 8'h68, AEpc = 8'h70, APrid = 8'h78;

  vec_t vecs [16];
  logic [7:0] addrs [8];

  initial begin
    logic found, wrapped;
    logic [31:0] pc0;
    pc0 = 32'hBFC0_0000;
    addrs = '{ACount, ACompare, AStatus, ACause, AEpc, APrid, 8'h71, 8'h00};

    vecs[0]  = '{1'b1, mk(0, 0, 0, 8'h0, 4'b0011, 5'd5, 32'h1234_5678, pc0), 4'b0011,
                 32'h1234_5678, 1'b0, 32'h0, {1'b1, 4'b0011, 5'd5}};
    vecs[1]  = '{1'b1, mk(0, 1, 0, AEpc, 4'h0, 5'd0, 32'hBFC0_0380, pc0 + 4), 4'h0,
                 32'hBFC0_0380, 1'b0, 32'h0, 10'h0};
    vecs[2]  = '{1'b1, mk(0, 0, 1, AEpc, 4'hF, 5'd3, 32'h0, pc0 + 8), 4'hF,
                 32'hBFC0_0380, 1'b0, 32'hBFC0_0380, {1'b1, 4'hF, 5'd3}};
    vecs[3]  = '{1'b1, mk(0, 1, 0, AStatus, 4'h0, 5'd0, 32'h0000_FF03, pc0 + 12), 4'h0,
                 32'h0000_FF03, 1'b0, 32'hBFC0_0380, 10'h0};
    vecs[4]  = '{1'b1, mk(0, 0, 1, AStatus, 4'hF, 5'd4, 32'h0, pc0 + 16), 4'hF,
                 32'h0040_FF03, 1'b0, 32'hBFC0_0380, {1'b1, 4'hF, 5'd4}};
    vecs[5]  = '{1'b1, mk(1, 0, 0, 8'h0, 4'h0, 5'd0, 32'h0, pc0 + 20), 4'h0,
                 32'h0, 1'b1, 32'hBFC0_0380, 10'h0};
    vecs[6]  = '{1'b1, mk(0, 0, 1, AStatus, 4'hF, 5'd6, 32'h0, pc0 + 24), 4'hF,
                 32'h0040_FF01, 1'b0, 32'hBFC0_0380, {1'b1, 4'hF, 5'd6}};
    vecs[7]  = '{1'b1, mk(0, 1, 0, APrid, 4'h0, 5'd0, 32'hDEAD_BEEF, pc0 + 28), 4'h0,
                 32'hDEAD_BEEF, 1'b0, 32'hBFC0_0380, 10'h0};
    vecs[8]  = '{1'b1, mk(0, 0, 1, APrid, 4'hF, 5'd7, 32'h5555, pc0 + 32), 4'hF,
                 32'h0, 1'b0, 32'hBFC0_0380, {1'b1, 4'hF, 5'd7}};
    vecs[9]  = '{1'b1, mk(0, 0, 1, 8'h71, 4'hF, 5'd8, 32'h0, pc0 + 36), 4'hF,
                 32'h0, 1'b0, 32'hBFC0_0380, {1'b1, 4'hF, 5'd8}};
    vecs[10] = '{1'b1, mk(0, 1, 0, AStatus, 4'h0, 5'd0, 32'hFFFF_FFFF, pc0 + 40), 4'h0,
                 32'hFFFF_FFFF, 1'b0, 32'hBFC0_0380, 10'h0};
    vecs[11] = '{1'b1, mk(0, 0, 1, AStatus, 4'hF, 5'd9, 32'h0, pc0 + 44), 4'hF,
                 32'h0040_FF03, 1'b0, 32'hBFC0_0380, {1'b1, 4'hF, 5'd9}};
    vecs[12] = '{1'b1, mk(0, 1, 0, ACompare, 4'h0, 5'd0, 32'hFFFF_0000, pc0 + 48), 4'h0,
                 32'hFFFF_0000, 1'b0, 32'hBFC0_0380, 10'h0};
    vecs[13] = '{1'b1, mk(0, 1, 0, ACause, 4'h0, 5'd0, 32'hFFFF_FFFF, pc0 + 52), 4'h0,
                 32'hFFFF_FFFF, 1'b0, 32'hBFC0_0380, 10'h0};
    vecs[14] = '{1'b1, mk(0, 0, 1, ACause, 4'hF, 5'd10, 32'h0, pc0 + 56), 4'hF,
                 32'h0000_0300, 1'b0, 32'hBFC0_0380, {1'b1, 4'hF, 5'd10}};
    // Bubble: the stage register keeps the previous instruction, only valid drops.
    vecs[15] = '{1'b0, mk(0, 0, 0, 8'h0, 4'hF, 5'd12, 32'h55, pc0 + 60), 4'h0,
                 32'h0000_0300, 1'b0, 32'hBFC0_0380, {1'b0, 4'h0, 5'd10}};

    // Reset held two cycles
    reset = 1'b0;
    step(1'b0, '0);
    step(1'b0, '0);
    chk("rst_rf_we", 64'(ws_to_rf_bus[40:37]), 64'h0);
    chk("rst_flush", 64'(ws_eret_flush), 64'h0);
    reset = 1'b1;
    step(1'b1, mk(0, 0, 1, AStatus, 4'hF, 5'd1, 32'h0, pc0));
    chk("rst_status", 64'(debug_wb_rf_wdata), 64'h0040_0000);
    step(1'b1, mk(0, 0, 1, ACount, 4'hF, 5'd1, 32'h0, pc0));
    chk("rst_count_small", 64'(debug_wb_rf_wdata < 32'd4), 64'h1);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].v, vecs[i].bus);
      chk($sformatf("vec%0d_we", i), 64'(ws_to_rf_bus[40:37]), 64'(vecs[i].exp_we));
      chk($sformatf("vec%0d_wdata", i), 64'(ws_to_rf_bus[31:0]), 64'(vecs[i].exp_wdata));
      chk($sformatf("vec%0d_flush", i), 64'(ws_eret_flush), 64'(vecs[i].exp_flush));
      chk($sformatf("vec%0d_epc", i), 64'(cp0_epc), 64'(vecs[i].exp_epc));
      chk($sformatf("vec%0d_stall", i), 64'(stall_ws_bus), 64'(vecs[i].exp_stall));
    end

    // Timer: Compare=4 from a fresh reset, poll Cause.TI
    reset = 1'b0;
    step(1'b0, '0);
    step(1'b0, '0);
    reset = 1'b1;
    step(1'b1, mk(0, 1, 0, ACompare, 4'h0, 5'd0, 32'd4, pc0));
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b1, mk(0, 0, 1, ACause, 4'hF, 5'd2, 32'h0, pc0));
      if (debug_wb_rf_wdata[30] && debug_wb_rf_wdata[15]) found = 1'b1;
    end
    chk("ti_set_in_time", 64'(found), 64'h1);
    step(1'b1, mk(0, 1, 0, ACompare, 4'h0, 5'd0, 32'd100, pc0));
    step(1'b1, mk(0, 0, 1, ACause, 4'hF, 5'd2, 32'h0, pc0));
    chk("ti_cleared", 64'(debug_wb_rf_wdata[30]), 64'h0);

    // Count wrap
    step(1'b1, mk(0, 1, 0, ACount, 4'h0, 5'd0, 32'hFFFF_FFFF, pc0));
    wrapped = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mk(0, 0, 1, ACount, 4'hF, 5'd3, 32'h0, pc0));
      if (debug_wb_rf_wdata == 32'h0) wrapped = 1'b1;
    end
    chk("count_wrap", 64'(wrapped), 64'h1);

    // Reset while an ERET sits in the stage
    step(1'b1, mk(0, 1, 0, AEpc, 4'h0, 5'd0, 32'h0000_1234, pc0));
    step(1'b1, mk(0, 1, 0, AStatus, 4'h0, 5'd0, 32'h0000_FF03, pc0));
    step(1'b1, mk(1, 0, 0, 8'h0, 4'h0, 5'd0, 32'h0, pc0 + 4));
    chk("eret_flush_hi", 64'(ws_eret_flush), 64'h1);
    chk("eret_epc", 64'(cp0_epc), 64'h1234);
    reset = 1'b0;
    step(1'b1, mk(1, 0, 0, 8'h0, 4'h0, 5'd0, 32'h0, pc0 + 8));
    chk("rst_flush_drop", 64'(ws_eret_flush), 64'h0);
    chk("rst_epc", 64'(cp0_epc), 64'h0);
    reset = 1'b1;
    step(1'b1, mk(0, 0, 1, AStatus, 4'hF, 5'd1, 32'h0, pc0));
    chk("rst2_status", 64'(debug_wb_rf_wdata), 64'h0040_0000);
    step(1'b1, mk(0, 0, 1, ACompare, 4'hF, 5'd1, 32'h0, pc0));
    chk("rst2_compare", 64'(debug_wb_rf_wdata), 64'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int kind;
      logic [7:0] a;
      logic [31:0] r;
      kind = int'($urandom_range(0, 9));
      a = addrs[$urandom_range(0, 7)];
      r = $urandom;
      case (kind)
        0, 1, 2, 3: step(1'b1, mk(0, 0, 0, 8'h0, 4'($urandom), 5'($urandom), r, $urandom));
        4, 5:       step(1'b1, mk(0, 1, 0, a, 4'h0, 5'd0, r, $urandom));
        6, 7:       step(1'b1, mk(0, 0, 1, a, 4'hF, 5'($urandom), r, $urandom));
        8:          step(1'b1, mk(1, 0, 0, 8'h0, 4'h0, 5'd0, 32'h0, $urandom));
        default:    step(1'b0, mk(1, 1, 1, a, 4'hF, 5'($urandom), r, $urandom));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
